// File: rtl/mux4_scan_ctrl_if.sv
// Bundle between mux4_scan_ctrl and its neighbours: mux4 select/sample and the word handshake.
// MUX4_SCAN_PARITY_EN adds word_par alongside word.
interface mux4_scan_ctrl_if;
  logic       en;
  logic       mux_o;
  logic       sel_j;
  logic       sel_k;
  logic [3:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
`ifdef MUX4_SCAN_PARITY_EN
  logic       word_par;

  modport master (
    input  en, mux_o, word_ready,
    output sel_j, sel_k, word, word_valid, busy, word_par
  );

  modport slave (
    output en, mux_o, word_ready,
    input  sel_j, sel_k, word, word_valid, busy, word_par
  );
`else
  modport master (
    input  en, mux_o, word_ready,
    output sel_j, sel_k, word, word_valid, busy
  );

  modport slave (
    output en, mux_o, word_ready,
    input  sel_j, sel_k, word, word_valid, busy
  );
`endif
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Sweeps mux4 select through channels 0..3, samples each after DWELL cycles, hands the 4-bit word downstream.
// MUX4_SCAN_PARITY_EN adds a registered even-parity bit (word_par) loaded with word.
//
// state | meaning
// IDLE  | not scanning, sel=00
// SCAN  | stepping channels, dwell counting, sampling
// HOLD  | word_valid high, waiting for word_ready, sel=00
module mux4_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input logic              clk,
  input logic              rst,
  mux4_scan_ctrl_if.master bus
);

  localparam int unsigned     CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       buf_q, buf_d;
  logic [3:0]       word_q, word_d;
  logic             valid_q, valid_d;
`ifdef MUX4_SCAN_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      buf_q   <= 3'd0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
`ifdef MUX4_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      valid_q <= valid_d;
`ifdef MUX4_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    word_d  = word_q;
    valid_d = valid_q;
`ifdef MUX4_SCAN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = ST_SCAN;
          idx_d   = 2'd0;
          cnt_d   = '0;
          buf_d   = 3'd0;
        end
      end
      ST_SCAN: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          buf_d   = 3'd0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (idx_q)
            2'd0: buf_d[0] = bus.mux_o;
            2'd1: buf_d[1] = bus.mux_o;
            2'd2: buf_d[2] = bus.mux_o;
            default: buf_d = buf_q;
          endcase
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            // Channel 3 goes straight into word; the buffer only holds 0..2.
            word_d  = {bus.mux_o, buf_q};
            valid_d = 1'b1;
            idx_d   = 2'd0;
            state_d = ST_HOLD;
`ifdef MUX4_SCAN_PARITY_EN
            par_d   = ^{bus.mux_o, buf_q};
`endif
          end
        end
      end
      ST_HOLD: begin
        if (valid_q && bus.word_ready) begin
          valid_d = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = '0;
          buf_d   = 3'd0;
          state_d = bus.en ? ST_SCAN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
        buf_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.sel_j      = idx_q[1];
  assign bus.sel_k      = idx_q[0];
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
`ifdef MUX4_SCAN_PARITY_EN
  assign bus.word_par   = par_q;
`endif

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: DWELL=2 and DWELL=1 instances against a positional sweep model.
// Build with MUX4_SCAN_PARITY_EN defined to also cover word_par.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] chan [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux4_scan_ctrl_if if0 ();
  mux4_scan_ctrl_if if1 ();

  mux4_scan_ctrl #(.DWELL(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  mux4_scan_ctrl #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  // mux4 stand-ins: bit i of chan[k] is channel i
  assign if0.en         = en;
  assign if0.word_ready = ready;
  assign if0.mux_o      = chan[0][{if0.sel_j, if0.sel_k}];
  assign if1.en         = en;
  assign if1.word_ready = ready;
  assign if1.mux_o      = chan[1][{if1.sel_j, if1.sel_k}];

  logic [1:0] d_sel   [2];
  logic [3:0] d_word  [2];
  logic       d_valid [2];
  logic       d_busy  [2];
  assign d_sel[0]   = {if0.sel_j, if0.sel_k};
  assign d_sel[1]   = {if1.sel_j, if1.sel_k};
  assign d_word[0]  = if0.word;
  assign d_word[1]  = if1.word;
  assign d_valid[0] = if0.word_valid;
  assign d_valid[1] = if1.word_valid;
  assign d_busy[0]  = if0.busy;
  assign d_busy[1]  = if1.busy;
`ifdef MUX4_SCAN_PARITY_EN
  logic d_par [2];
  assign d_par[0] = if0.word_par;
  assign d_par[1] = if1.word_par;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 scanning, 2 holding; pos = scan edges taken in the current sweep.
  int         dw     [2] = '{2, 1};
  int         m_mode [2] = '{0, 0};
  int         m_pos  [2] = '{0, 0};
  logic [3:0] m_buf  [2] = '{4'd0, 4'd0};
  logic [3:0] m_word [2] = '{4'd0, 4'd0};
  logic       m_valid[2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      int         mode, pos, ch;
      logic [3:0] b, w;
      logic       v;
      mode = m_mode[k]; pos = m_pos[k]; b = m_buf[k]; w = m_word[k]; v = m_valid[k];
      if (rst) begin
        mode = 0; pos = 0; b = 4'd0; w = 4'd0; v = 1'b0;
      end else if (mode == 0) begin
        if (en) begin mode = 1; pos = 0; end
      end else if (mode == 1) begin
        if (!en) begin
          mode = 0; pos = 0; b = 4'd0;
        end else begin
          ch = pos / dw[k];
          if (pos % dw[k] == dw[k] - 1) b[ch] = chan[k][ch];
          pos = pos + 1;
          if (pos == 4 * dw[k]) begin
            w = b; v = 1'b1; mode = 2; pos = 0;
          end
        end
      end else begin
        if (ready) begin v = 1'b0; mode = en ? 1 : 0; pos = 0; end
      end
      m_mode[k]  <= mode;
      m_pos[k]   <= pos;
      m_buf[k]   <= b;
      m_word[k]  <= w;
      m_valid[k] <= v;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] es;
      es = (m_mode[k] == 1) ? 2'(m_pos[k] / dw[k]) : 2'd0;
      chk($sformatf("model_sel%0d", k),   8'(d_sel[k]),   8'(es));
      chk($sformatf("model_word%0d", k),  8'(d_word[k]),  8'(m_word[k]));
      chk($sformatf("model_valid%0d", k), 8'(d_valid[k]), 8'(m_valid[k]));
      chk($sformatf("model_busy%0d", k),  8'(d_busy[k]),  8'(m_mode[k] != 0));
`ifdef MUX4_SCAN_PARITY_EN
      chk($sformatf("model_par%0d", k),   8'(d_par[k]),   8'(^m_word[k]));
`endif
    end
  end

  task automatic wait_valid(input int k, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_valid[k] && n < budget);
    chk($sformatf("wait_valid%0d", k), 8'(d_valid[k]), 8'd1);
  endtask

  initial begin
    int n;
    chan[0] = 4'b0101;
    chan[1] = 4'b0110;
    en = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_sel",   8'(d_sel[0]),   8'd0);
    chk("rst_word",  8'(d_word[0]),  8'd0);
    chk("rst_valid", 8'(d_valid[0]), 8'd0);
    chk("rst_busy",  8'(d_busy[0]),  8'd0);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", 8'(d_busy[0]), 8'd0);
    chk("idle_word", 8'(d_word[0]), 8'd0);

    // Basic sweep, DWELL=2
    ready = 1'b1;
    en    = 1'b1;
    wait_valid(0, 50, n);
    chk("lat_basic",  8'(n), 8'd9);
    chk("word_basic", 8'(d_word[0]), 8'b0101);
    @(negedge clk);
    chk("valid_one_cycle", 8'(d_valid[0]), 8'd0);
    chk("restart_busy",    8'(d_busy[0]),  8'd1);

    // Backpressure
    ready = 1'b0;
    wait_valid(0, 50, n);
    chk("word_bp_first", 8'(d_word[0]), 8'b0101);
    chan[0] = 4'b1111;
    repeat (20) begin
      @(negedge clk);
      chk("stall_word",  8'(d_word[0]),  8'b0101);
      chk("stall_valid", 8'(d_valid[0]), 8'd1);
      chk("stall_sel",   8'(d_sel[0]),   8'd0);
      chk("stall_busy",  8'(d_busy[0]),  8'd1);
    end
    ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d_valid[0] && n > 1) && n < 50);
    chk("bp_valid", 8'(d_valid[0]), 8'd1);
    chk("lat_bp",   8'(n), 8'd9);
    chk("word_bp",  8'(d_word[0]), 8'b1111);

    // Abort on channel 2
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_sel[0] != 2'd2 && n < 50);
    chk("reach_ch2", 8'(d_sel[0]), 8'd2);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy",  8'(d_busy[0]),  8'd0);
    chk("abort_sel",   8'(d_sel[0]),   8'd0);
    chk("abort_word",  8'(d_word[0]),  8'b1111);
    chk("abort_valid", 8'(d_valid[0]), 8'd0);
    repeat (10) begin
      @(negedge clk);
      chk("abort_novalid", 8'(d_valid[0]), 8'd0);
    end
    chan[0] = 4'b0011;
    en = 1'b1;
    wait_valid(0, 50, n);
    chk("lat_fresh",  8'(n), 8'd9);
    chk("word_fresh", 8'(d_word[0]), 8'b0011);

    // DWELL=1 cadence and select stepping
    wait_valid(1, 50, n);
    repeat (2) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("d1_sel", 8'(d_sel[1]), 8'(i));
        chk("d1_novalid", 8'(d_valid[1]), 8'd0);
      end
      @(negedge clk);
      chk("d1_valid", 8'(d_valid[1]), 8'd1);
      chk("d1_word",  8'(d_word[1]),  8'b0110);
    end

`ifdef MUX4_SCAN_PARITY_EN
    chan[0] = 4'b0101;
    wait_valid(0, 50, n);
    @(negedge clk);
    wait_valid(0, 50, n);
    chk("par_word0", 8'(d_word[0]), 8'b0101);
    chk("par0",      8'(d_par[0]),  8'd0);
    chan[0] = 4'b0111;
    @(negedge clk);
    wait_valid(0, 50, n);
    @(negedge clk);
    wait_valid(0, 50, n);
    chk("par_word1", 8'(d_word[0]), 8'b0111);
    chk("par1",      8'(d_par[0]),  8'd1);
`endif

    // Randomized traffic with occasional resets
    repeat (3000) begin
      @(negedge clk);
      en    = ($urandom_range(0, 15) != 0);
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) chan[0] = 4'($urandom);
      if ($urandom_range(0, 7) == 0) chan[1] = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rnd_rst_valid", 8'(d_valid[0] | d_valid[1]), 8'd0);
        chk("rnd_rst_busy",  8'(d_busy[0] | d_busy[1]),   8'd0);
        chk("rnd_rst_word",  8'(d_word[0] | d_word[1]),   8'd0);
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
